// File: rtl/mb_bram_port_ctrl.sv
// mb_bram_port_ctrl: turns a valid/ready command channel into single-cycle
// accesses on one 32-bit BRAM port. It returns in-order responses over a
// valid/ready channel with backpressure.
//
// Timeline for a command accepted on the edge that ends cycle C:
//   C+1 (T)   : registered BRAM_EN/WEN/Addr/Dout drive the port.
//   C+2 (T+1) : BRAM_Din is valid. The response is formed here. If the FIFO
//               is empty, the response is presented directly; otherwise it is
//               pushed behind the FIFO contents.
//
// The credit counter covers everything in flight: issue + capture + FIFO.
// A pop in the same cycle frees a credit, so Cmd_Ready also opens on a pop.
// This lets a stream run at one command per cycle while staying within two
// credits.
module mb_bram_port_ctrl #(
  parameter int unsigned              C_PORT_AWIDTH = 32,
  parameter int unsigned              C_PORT_DWIDTH = 32,
  parameter int unsigned              C_NUM_WE      = C_PORT_DWIDTH / 8,
  parameter logic [C_PORT_AWIDTH-1:0] C_BASEADDR    = '0,
  parameter logic [C_PORT_AWIDTH-1:0] C_MEMSIZE     = C_PORT_AWIDTH'(32'h0001_0000)
) (
  input  logic                     Clk,
  input  logic                     Rst_N,
  input  logic                     Cmd_Valid,
  output logic                     Cmd_Ready,
  input  logic                     Cmd_Write,
  input  logic [0:C_PORT_AWIDTH-1] Cmd_Addr,
  input  logic [0:C_NUM_WE-1]      Cmd_BE,
  input  logic [0:C_PORT_DWIDTH-1] Cmd_WData,
  output logic                     Rsp_Valid,
  input  logic                     Rsp_Ready,
  output logic                     Rsp_Write,
  output logic                     Rsp_Err,
  output logic [0:C_PORT_DWIDTH-1] Rsp_RData,
  output logic                     BRAM_Rst,
  output logic                     BRAM_Clk,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);
  localparam int unsigned AW = C_PORT_AWIDTH;
  localparam int unsigned DW = C_PORT_DWIDTH;
  localparam int unsigned NW = C_NUM_WE;

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic          bram_rst_q, bram_rst_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          en_q, en_d;
  logic [NW-1:0] wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  // bit 0: issue stage (cycle T), bit 1: capture stage (cycle T+1)
  logic [1:0]    vld_pipe_q, vld_pipe_d;
  logic [1:0]    wr_pipe_q, wr_pipe_d;
  logic [1:0]    err_pipe_q, err_pipe_d;
  rsp_t          fifo_q [0:1];
  rsp_t          fifo_d [0:1];
  logic          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]    fcnt_q, fcnt_d;

  logic [AW-1:0] offset;
  logic          in_rng, accept, pop, fifo_pop, push, rsp_vld;
  rsp_t          cap_ent, head;

  assign BRAM_Clk  = Clk;
  assign BRAM_Rst  = bram_rst_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WEN  = wen_q;
  assign BRAM_Addr = addr_q;
  assign BRAM_Dout = dout_q;

  // Decode, credit accounting, port drive and response FIFO next-state
  always_comb begin
    offset  = Cmd_Addr - C_BASEADDR;
    in_rng  = offset < C_MEMSIZE;

    cap_ent.wr   = vld_pipe_q[1] & wr_pipe_q[1];
    cap_ent.err  = vld_pipe_q[1] & err_pipe_q[1];
    cap_ent.data = (vld_pipe_q[1] && !wr_pipe_q[1] && !err_pipe_q[1]) ? DW'(BRAM_Din) : '0;

    head     = (fcnt_q != 2'd0) ? fifo_q[rd_ptr_q] : cap_ent;
    rsp_vld  = (fcnt_q != 2'd0) | vld_pipe_q[1];
    pop      = rsp_vld & Rsp_Ready;
    fifo_pop = pop & (fcnt_q != 2'd0);
    // The capture entry bypasses the FIFO when it is the head and is popped
    push     = vld_pipe_q[1] & ~((fcnt_q == 2'd0) & pop);

    Cmd_Ready = ~bram_rst_q & ((cnt_q < 2'd2) | pop);
    accept    = Cmd_Valid & Cmd_Ready;

    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !accept) cnt_d = cnt_q - 2'd1;

    bram_rst_d = 1'b0;
    en_d       = accept & in_rng;
    wen_d      = (accept && in_rng && Cmd_Write) ? NW'(Cmd_BE) : '0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    if (accept && in_rng) begin
      addr_d = offset & ~AW'(3);
      dout_d = Cmd_WData;
    end

    vld_pipe_d = {vld_pipe_q[0], accept};
    wr_pipe_d  = {wr_pipe_q[0], Cmd_Write};
    err_pipe_d = {err_pipe_q[0], ~in_rng};

    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    if (push) fifo_d[wr_ptr_q] = cap_ent;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ fifo_pop;
    fcnt_d   = fcnt_q;
    if (push && !fifo_pop)      fcnt_d = fcnt_q + 2'd1;
    else if (fifo_pop && !push) fcnt_d = fcnt_q - 2'd1;

    Rsp_Valid = rsp_vld;
    Rsp_Write = head.wr;
    Rsp_Err   = head.err;
    Rsp_RData = head.data;
  end

  // State registers; reset drops all in-flight and buffered responses
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      bram_rst_q <= 1'b1;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      wen_q      <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      vld_pipe_q <= '0;
      wr_pipe_q  <= '0;
      err_pipe_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      bram_rst_q <= bram_rst_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      vld_pipe_q <= vld_pipe_d;
      wr_pipe_q  <= wr_pipe_d;
      err_pipe_q <= err_pipe_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_mb_bram_port_ctrl.sv
// Bench for mb_bram_port_ctrl: a behavioral 1-cycle-latency BRAM, a directed
// vector table, and hand-written backpressure / streaming / reset sequences.
module tb_mb_bram_port_ctrl;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        Clk, Rst_N;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Write;
  logic [0:31] Cmd_Addr, Cmd_WData, Rsp_RData, BRAM_Addr, BRAM_Dout, BRAM_Din;
  logic [0:3]  Cmd_BE, BRAM_WEN;
  logic        Rsp_Valid, Rsp_Ready, Rsp_Write, Rsp_Err;
  logic        BRAM_Rst, BRAM_Clk, BRAM_EN;

  int checks = 0;
  int failures = 0;

  mb_bram_port_ctrl #(.C_BASEADDR(BASE)) dut (
    .Clk(Clk), .Rst_N(Rst_N),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .Cmd_Addr(Cmd_Addr), .Cmd_BE(Cmd_BE), .Cmd_WData(Cmd_WData),
    .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Write(Rsp_Write),
    .Rsp_Err(Rsp_Err), .Rsp_RData(Rsp_RData),
    .BRAM_Rst(BRAM_Rst), .BRAM_Clk(BRAM_Clk), .BRAM_EN(BRAM_EN),
    .BRAM_WEN(BRAM_WEN), .BRAM_Addr(BRAM_Addr), .BRAM_Dout(BRAM_Dout),
    .BRAM_Din(BRAM_Din)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioral BRAM: read-before-write, data out one cycle after EN
  logic [0:31] mem [0:16383];
  initial for (int i = 0; i < 16384; i++) mem[i] = '0;
  always @(posedge Clk) begin
    if (BRAM_EN) begin
      BRAM_Din <= mem[BRAM_Addr[16:29]];
      for (int b = 0; b < 4; b++)
        if (BRAM_WEN[b]) mem[BRAM_Addr[16:29]][8*b +: 8] <= BRAM_Dout[8*b +: 8];
    end
  end

  // A push into a full response FIFO must never happen
  always @(posedge Clk) begin
    if (Rst_N && dut.push && dut.fcnt_q == 2'd2) begin
      failures++;
      $display("FAIL fifo_overflow push into full FIFO at %0t", $time);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    Cmd_Valid = v; Cmd_Write = wr; Cmd_Addr = a; Cmd_BE = be; Cmd_WData = wd;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] baddr;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  // One isolated command: accept, check port drive at T, response at T+1
  task automatic apply_vec(input vec_t v);
    set_cmd(1'b1, v.wr, v.addr, v.be, v.wdata);
    #1 chk("cmd_ready", 32'(Cmd_Ready), 32'(1'b1));
    tick();
    Cmd_Valid = 1'b0;
    #1;
    chk("bram_en", 32'(BRAM_EN), 32'(v.en));
    chk("bram_wen", 32'(BRAM_WEN), 32'(v.wen));
    if (v.en) chk("bram_addr", BRAM_Addr, v.baddr);
    if (v.en && v.wr) chk("bram_dout", BRAM_Dout, v.wdata);
    chk("rsp_early", 32'(Rsp_Valid), 32'(1'b0));
    tick();
    chk("rsp_valid", 32'(Rsp_Valid), 32'(1'b1));
    chk("rsp_write", 32'(Rsp_Write), 32'(v.wr));
    chk("rsp_err", 32'(Rsp_Err), 32'(v.err));
    chk("rsp_rdata", Rsp_RData, v.rdata);
    tick();
    chk("rsp_popped", 32'(Rsp_Valid), 32'(1'b0));
    chk("en_idle", 32'(BRAM_EN), 32'(1'b0));
  endtask

  vec_t vecs [0:12];
  logic [31:0] bp_addr [0:3];
  logic [31:0] bp_exp [0:3];
  logic [31:0] got_q[$];
  int acc, c, k;
  logic a_ok, r_ok;
  logic [31:0] r_dat;

  initial begin
    // Bench-computed expectations; the window is [BASE, BASE+'h10000)
    vecs[0]  = '{1'b1, BASE+32'h10,    4'b1111, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h10,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, BASE+32'h12,    4'b0000, 32'h0,        1'b1, 4'b0000, 32'h10,   1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, BASE+32'h10,    4'b0100, 32'h11223344, 1'b1, 4'b0100, 32'h10,   1'b0, 32'h0};
    vecs[3]  = '{1'b0, BASE+32'h13,    4'b0000, 32'h0,        1'b1, 4'b0000, 32'h10,   1'b0, 32'hDE22BEEF};
    vecs[4]  = '{1'b0, BASE+32'h10000, 4'b0000, 32'h0,        1'b0, 4'b0000, 32'h0,    1'b1, 32'h0};
    vecs[5]  = '{1'b1, BASE+32'hFFFC,  4'b1111, 32'hCAFEF00D, 1'b1, 4'b1111, 32'hFFFC, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, BASE+32'hFFFF,  4'b0000, 32'h0,        1'b1, 4'b0000, 32'hFFFC, 1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, BASE+32'h10002, 4'b1111, 32'h55555555, 1'b0, 4'b0000, 32'h0,    1'b1, 32'h0};
    vecs[8]  = '{1'b1, BASE+32'h20,    4'b0000, 32'h12345678, 1'b1, 4'b0000, 32'h20,   1'b0, 32'h0};
    vecs[9]  = '{1'b0, BASE+32'h20,    4'b0000, 32'h0,        1'b1, 4'b0000, 32'h20,   1'b0, 32'h0};
    vecs[10] = '{1'b1, BASE+32'h20,    4'b1001, 32'hA1B2C3D4, 1'b1, 4'b1001, 32'h20,   1'b0, 32'h0};
    vecs[11] = '{1'b0, BASE+32'h20,    4'b0000, 32'h0,        1'b1, 4'b0000, 32'h20,   1'b0, 32'hA10000D4};
    vecs[12] = '{1'b0, BASE-32'h4,     4'b0000, 32'h0,        1'b0, 4'b0000, 32'h0,    1'b1, 32'h0};

    // Reset values
    Rst_N = 1'b0; Rsp_Ready = 1'b0;
    set_cmd(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) tick();
    chk("rst_bram_rst", 32'(BRAM_Rst), 32'(1'b1));
    chk("rst_en", 32'(BRAM_EN), 32'(1'b0));
    chk("rst_wen", 32'(BRAM_WEN), 32'h0);
    chk("rst_rsp_valid", 32'(Rsp_Valid), 32'(1'b0));
    chk("rst_cmd_ready", 32'(Cmd_Ready), 32'(1'b0));
    Rst_N = 1'b1;
    #1 chk("rel_bram_rst_held", 32'(BRAM_Rst), 32'(1'b1));
    tick();
    chk("rel_bram_rst", 32'(BRAM_Rst), 32'(1'b0));
    chk("rel_cmd_ready", 32'(Cmd_Ready), 32'(1'b1));

    // Directed vector table
    Rsp_Ready = 1'b1;
    for (int i = 0; i < 13; i++) apply_vec(vecs[i]);

    // Backpressure: four reads offered with Rsp_Ready low
    bp_addr[0] = BASE+32'h10;   bp_exp[0] = 32'hDE22BEEF;
    bp_addr[1] = BASE+32'hFFFC; bp_exp[1] = 32'hCAFEF00D;
    bp_addr[2] = BASE+32'h20;   bp_exp[2] = 32'hA10000D4;
    bp_addr[3] = BASE+32'h14;   bp_exp[3] = 32'h0;
    Rsp_Ready = 1'b0; k = 0; got_q.delete();
    for (c = 0; c < 30; c++) begin
      if (c == 6) begin
        chk("bp_accepted_2", 32'(k), 32'd2);
        chk("bp_ready_low", 32'(Cmd_Ready), 32'(1'b0));
        Rsp_Ready = 1'b1;
      end
      set_cmd(k < 4, 1'b0, (k < 4) ? bp_addr[k] : 32'h0, 4'h0, 32'h0);
      #1;
      a_ok = Cmd_Valid & Cmd_Ready;
      r_ok = Rsp_Valid & Rsp_Ready;
      r_dat = Rsp_RData;
      tick();
      if (a_ok) k++;
      if (r_ok) got_q.push_back(r_dat);
      if (c >= 6 && k == 4 && got_q.size() == 4) break;
    end
    Cmd_Valid = 1'b0;
    chk("bp_accepted_all", 32'(k), 32'd4);
    chk("bp_rsp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("bp_rsp_order", got_q[i], bp_exp[i]);
    tick();

    // Streaming: 16 writes then 16 reads, one per cycle, responses two cycles behind
    for (int pass = 0; pass < 2; pass++) begin
      acc = 0;
      for (c = 0; c < 20; c++) begin
        set_cmd(c < 16, pass == 0, BASE + 32'h100 + 32'(4*c), 4'b1111, 32'h5A00_0000 + 32'(c));
        #1;
        if (c < 16 && Cmd_Ready) acc++;
        chk("stream_rsp_valid", 32'(Rsp_Valid), 32'(c >= 2 && c < 18));
        if (c >= 2 && c < 18) begin
          chk("stream_rsp_write", 32'(Rsp_Write), 32'(pass == 0));
          if (pass == 1) chk("stream_rdata", Rsp_RData, 32'h5A00_0000 + 32'(c - 2));
        end
        tick();
      end
      chk("stream_accepts", 32'(acc), 32'd16);
    end
    Cmd_Valid = 1'b0;
    tick();

    // Reset in the middle of a read stream
    for (c = 0; c < 5; c++) begin
      set_cmd(1'b1, 1'b0, BASE + 32'h100 + 32'(4*c), 4'h0, 32'h0);
      tick();
    end
    Rst_N = 1'b0; Cmd_Valid = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(Rsp_Valid), 32'(1'b0));
    chk("mid_rst_en", 32'(BRAM_EN), 32'(1'b0));
    chk("mid_rst_bram_rst", 32'(BRAM_Rst), 32'(1'b1));
    chk("mid_rst_ready", 32'(Cmd_Ready), 32'(1'b0));
    repeat (2) tick();
    Rst_N = 1'b1;
    for (c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_no_stale", 32'(Rsp_Valid), 32'(1'b0));
      chk("post_rst_en", 32'(BRAM_EN), 32'(1'b0));
    end
    vecs[0] = '{1'b0, BASE+32'h104, 4'b0000, 32'h0, 1'b1, 4'b0000, 32'h104, 1'b0, 32'h5A000001};
    apply_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
